// File: rtl/l2_port_arbiter_pkg.sv
// Shared types for the L2 port arbiter: arbitration states and the default
// width of the performance counters.
package rv32i_types;

  localparam int perf_counter_width = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Bundles the I-cache, D-cache and L2 memory-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and L2.
interface l2_port_arbiter_if;

  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;

  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;

  logic         a_pmem_read;
  logic         a_pmem_write;
  logic [31:0]  a_pmem_address;
  logic [255:0] a_pmem_wdata;
  logic [255:0] a_pmem_rdata;
  logic         a_pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output a_pmem_read, a_pmem_write, a_pmem_address, a_pmem_wdata,
    input  a_pmem_rdata, a_pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  a_pmem_read, a_pmem_write, a_pmem_address, a_pmem_wdata,
    output a_pmem_rdata, a_pmem_resp
  );

endinterface

// File: rtl/l2_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 port between I-cache and D-cache,
// holding each grant until the L2 responds, with per-requester wait counters.
//
// state   | meaning
// IDLE    | no grant held; arbitrates pending requests
// SERVE_I | L2 port owned by the I-cache until resp or request drop
// SERVE_D | L2 port owned by the D-cache until resp or request drop
module l2_port_arbiter
  import rv32i_types::*;
#(
  parameter int PERF_W = perf_counter_width
) (
  input  logic              clk,
  input  logic              rst,
  l2_port_arbiter_if.slave  bus,
  output logic [PERF_W-1:0] i_wait_cycles,
  output logic [PERF_W-1:0] d_wait_cycles,
  output logic [PERF_W-1:0] grant_count
);

  arb_state_t state;
  logic       last_d;
  logic       i_req;
  logic       d_req;
  logic       serve_i;
  logic       serve_d;
  logic       grant;

  assign i_req   = bus.i_pmem_read;
  assign d_req   = bus.d_pmem_read | bus.d_pmem_write;
  assign serve_i = (state == SERVE_I);
  assign serve_d = (state == SERVE_D);
  assign grant   = (state == IDLE) & (i_req | d_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the D-cache wins unless it was the last one served.
          if (d_req && (!i_req || !last_d)) begin
            state  <= SERVE_D;
            last_d <= 1'b1;
          end else if (i_req) begin
            state  <= SERVE_I;
            last_d <= 1'b0;
          end
        end
        SERVE_I: if (bus.a_pmem_resp || !i_req) state <= IDLE;
        SERVE_D: if (bus.a_pmem_resp || !d_req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back takes precedence when the D-cache raises read and write together.
  assign bus.a_pmem_read    = (serve_i & bus.i_pmem_read)
                            | (serve_d & bus.d_pmem_read & ~bus.d_pmem_write);
  assign bus.a_pmem_write   = serve_d & bus.d_pmem_write;
  assign bus.a_pmem_address = serve_i ? bus.i_pmem_address : bus.d_pmem_address;
  assign bus.a_pmem_wdata   = bus.d_pmem_wdata;

  assign bus.i_pmem_rdata = bus.a_pmem_rdata;
  assign bus.d_pmem_rdata = bus.a_pmem_rdata;
  assign bus.i_pmem_resp  = serve_i & i_req & bus.a_pmem_resp;
  assign bus.d_pmem_resp  = serve_d & d_req & bus.a_pmem_resp;

  sat_counter #(.W(PERF_W)) u_i_wait (
    .clk   (clk),
    .clr   (rst),
    .en    (i_req & ~serve_i),
    .count (i_wait_cycles)
  );

  sat_counter #(.W(PERF_W)) u_d_wait (
    .clk   (clk),
    .clr   (rst),
    .en    (d_req & ~serve_d),
    .count (d_wait_cycles)
  );

  sat_counter #(.W(PERF_W)) u_grants (
    .clk   (clk),
    .clr   (rst),
    .en    (grant),
    .count (grant_count)
  );

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: a 32-bit-counter instance for the main
// sequences and a 4-bit-counter instance for counter saturation.
module tb_l2_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] i_wait, d_wait, grants;
  logic [3:0]  i_wait4, d_wait4, grants4;

  int checks   = 0;
  int failures = 0;

  logic [255:0] line_a5;
  logic [255:0] line_x;
  logic [255:0] line_y;

  l2_port_arbiter_if bus ();
  l2_port_arbiter_if bus4 ();

  l2_port_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .i_wait_cycles (i_wait),
    .d_wait_cycles (d_wait),
    .grant_count   (grants)
  );

  l2_port_arbiter #(.PERF_W(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus4),
    .i_wait_cycles (i_wait4),
    .d_wait_cycles (d_wait4),
    .grant_count   (grants4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    line_a5 = {32{8'hA5}};
    line_x  = {8{32'hDEAD_0001}};
    line_y  = {8{32'h1234_5678}};

    bus.i_pmem_read = 0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 0; bus.d_pmem_write = 0; bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    bus.a_pmem_rdata = '0; bus.a_pmem_resp = 0;
    bus4.i_pmem_read = 0; bus4.i_pmem_address = '0;
    bus4.d_pmem_read = 0; bus4.d_pmem_write = 0; bus4.d_pmem_address = '0; bus4.d_pmem_wdata = '0;
    bus4.a_pmem_rdata = '0; bus4.a_pmem_resp = 0;

    // Reset state
    next(); next();
    rst = 0;
    settle();
    chk("rst_a_read", bus.a_pmem_read, 0);
    chk("rst_a_write", bus.a_pmem_write, 0);
    chk("rst_i_resp", bus.i_pmem_resp, 0);
    chk("rst_d_resp", bus.d_pmem_resp, 0);
    chk("rst_grants", grants, 0);
    chk("rst_i_wait", i_wait, 0);
    chk("rst_d_wait", d_wait, 0);

    // I-cache alone, L2 answers in the fifth serve cycle
    next();
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_1000;
    settle();
    chk("t1_idle_a_read", bus.a_pmem_read, 0);
    next();
    chk("t1_a_read", bus.a_pmem_read, 1);
    chk("t1_a_addr", bus.a_pmem_address, 32'h0000_1000);
    chk("t1_grants", grants, 1);
    repeat (4) next();
    chk("t1_hold_a_read", bus.a_pmem_read, 1);
    bus.a_pmem_resp = 1; bus.a_pmem_rdata = line_x;
    settle();
    chk("t1_i_resp", bus.i_pmem_resp, 1);
    chk("t1_d_resp", bus.d_pmem_resp, 0);
    chk("t1_i_rdata", bus.i_pmem_rdata, line_x);
    next();
    bus.a_pmem_resp = 0; bus.i_pmem_read = 0;
    settle();
    chk("t1_after_i_resp", bus.i_pmem_resp, 0);
    chk("t1_after_a_read", bus.a_pmem_read, 0);
    chk("t1_after_grants", grants, 1);
    chk("t1_i_wait", i_wait, 1);
    bus.a_pmem_resp = 1;
    settle();
    chk("t1_stray_i_resp", bus.i_pmem_resp, 0);
    chk("t1_stray_d_resp", bus.d_pmem_resp, 0);
    bus.a_pmem_resp = 0;

    // Simultaneous I and D after reset: D first, then I after one bubble
    rst = 1;
    next();
    rst = 0;
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_2000;
    bus.d_pmem_read = 1; bus.d_pmem_address = 32'h0000_3000;
    settle();
    chk("t2_idle_a_read", bus.a_pmem_read, 0);
    next();
    chk("t2_d_addr", bus.a_pmem_address, 32'h0000_3000);
    chk("t2_d_a_read", bus.a_pmem_read, 1);
    chk("t2_grants1", grants, 1);
    next(); next();
    bus.a_pmem_resp = 1; bus.a_pmem_rdata = line_y;
    settle();
    chk("t2_d_resp", bus.d_pmem_resp, 1);
    chk("t2_i_resp_quiet", bus.i_pmem_resp, 0);
    chk("t2_d_rdata", bus.d_pmem_rdata, line_y);
    next();
    bus.a_pmem_resp = 0; bus.d_pmem_read = 0;
    settle();
    chk("t2_bubble_a_read", bus.a_pmem_read, 0);
    chk("t2_i_wait_bubble", i_wait, 4);
    next();
    chk("t2_i_addr", bus.a_pmem_address, 32'h0000_2000);
    chk("t2_i_a_read", bus.a_pmem_read, 1);
    chk("t2_i_wait", i_wait, 5);
    chk("t2_d_wait", d_wait, 1);
    chk("t2_grants2", grants, 2);
    bus.a_pmem_resp = 1;
    settle();
    chk("t2_i_resp", bus.i_pmem_resp, 1);
    next();
    bus.a_pmem_resp = 0; bus.i_pmem_read = 0;

    // Four back-to-back ties alternate D, I, D, I
    rst = 1;
    next();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      bus.i_pmem_read = 1; bus.d_pmem_read = 1;
      next();
      chk($sformatf("t3_addr_%0d", k), bus.a_pmem_address,
          (k % 2 == 0) ? 32'h0000_3000 : 32'h0000_2000);
      bus.a_pmem_resp = 1;
      settle();
      chk($sformatf("t3_d_resp_%0d", k), bus.d_pmem_resp, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_i_resp_%0d", k), bus.i_pmem_resp, (k % 2 == 0) ? 0 : 1);
      next();
      bus.a_pmem_resp = 0; bus.i_pmem_read = 0; bus.d_pmem_read = 0;
      next();
    end
    chk("t3_grants", grants, 4);

    // D read and write together: write wins; then request dropped before resp
    bus.d_pmem_read = 1; bus.d_pmem_write = 1;
    bus.d_pmem_address = 32'h0000_4000; bus.d_pmem_wdata = line_a5;
    next();
    chk("t4_a_write", bus.a_pmem_write, 1);
    chk("t4_a_read", bus.a_pmem_read, 0);
    chk("t4_a_wdata", bus.a_pmem_wdata, line_a5);
    chk("t4_a_addr", bus.a_pmem_address, 32'h0000_4000);
    bus.d_pmem_read = 0; bus.d_pmem_write = 0;
    settle();
    chk("t4_drop_a_write", bus.a_pmem_write, 0);
    next();
    bus.a_pmem_resp = 1;
    settle();
    chk("t4_late_d_resp", bus.d_pmem_resp, 0);
    chk("t4_grants", grants, 5);
    bus.a_pmem_resp = 0;

    // Reset in the middle of an I-cache transaction
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h0000_5000;
    next();
    chk("t5_a_read", bus.a_pmem_read, 1);
    rst = 1;
    next();
    rst = 0;
    settle();
    chk("t5_rst_a_read", bus.a_pmem_read, 0);
    chk("t5_rst_grants", grants, 0);
    chk("t5_rst_i_wait", i_wait, 0);
    chk("t5_rst_d_wait", d_wait, 0);
    bus.a_pmem_resp = 1;
    settle();
    chk("t5_late_i_resp", bus.i_pmem_resp, 0);
    bus.i_pmem_read = 0; bus.a_pmem_resp = 0;

    // 4-bit counters: I starved by a 20-cycle D service saturates at 15
    bus4.i_pmem_read = 1; bus4.d_pmem_read = 1;
    next();
    chk("t6_d_granted", bus4.a_pmem_address, 32'h0);
    chk("t6_a_read", bus4.a_pmem_read, 1);
    chk("t6_i_wait1", i_wait4, 1);
    repeat (13) next();
    chk("t6_i_wait14", i_wait4, 14);
    repeat (6) next();
    chk("t6_i_wait_sat", i_wait4, 15);
    chk("t6_d_wait", d_wait4, 1);
    chk("t6_grants", grants4, 1);
    bus4.a_pmem_resp = 1;
    settle();
    chk("t6_d_resp", bus4.d_pmem_resp, 1);
    chk("t6_i_resp", bus4.i_pmem_resp, 0);
    next();
    bus4.a_pmem_resp = 0; bus4.d_pmem_read = 0; bus4.i_pmem_read = 0;
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Round-robin arbiter that shares the single 256-bit L2 cache port between the I-cache and D-cache miss/write-back paths. It sits between the two L1 caches and `l2_cache`, replacing the fixed-priority arbiter control/datapath pair with one self-contained block. It also carries per-requester contention counters for performance analysis. Each grant is held from acceptance until the L2 responds, so at most one L2 transaction is ever in flight.

## Interface
- `PERF_W`, 32: width of each saturating performance counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_pmem_read` input 1: I-cache line-fill request.
- `i_pmem_address` input 32: I-cache line address.
- `i_pmem_rdata` output 256: fill data to the I-cache.
- `i_pmem_resp` output 1: completion pulse to the I-cache.
- `d_pmem_read` input 1: D-cache line-fill request.
- `d_pmem_write` input 1: D-cache write-back request.
- `d_pmem_address` input 32: D-cache line address.
- `d_pmem_wdata` input 256: D-cache write-back line.
- `d_pmem_rdata` output 256: fill data to the D-cache.
- `d_pmem_resp` output 1: completion pulse to the D-cache.
- `a_pmem_read` output 1: read request to L2.
- `a_pmem_write` output 1: write request to L2.
- `a_pmem_address` output 32: address to L2.
- `a_pmem_wdata` output 256: write line to L2.
- `a_pmem_rdata` input 256: L2 read data.
- `a_pmem_resp` input 1: L2 completion pulse.
- `i_wait_cycles` output PERF_W: cycles I-cache request pending but not granted.
- `d_wait_cycles` output PERF_W: cycles D-cache request pending but not granted.
- `grant_count` output PERF_W: total grants issued.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- `i_req` = `i_pmem_read`; `d_req` = `d_pmem_read | d_pmem_write`.
- IDLE:
  - only `i_req`: go to SERVE_I.
  - only `d_req`: go to SERVE_D.
  - both: grant the requester not served last (`last_d` token).
  - Each grant sets `last_d` and increments `grant_count`.
- SERVE_X:
  - L2 port driven from requester X.
  - On `a_pmem_resp`, `x_pmem_resp` = 1 for that cycle; return to IDLE.
- Request dropped while in SERVE_X before resp: L2 request deasserts the same cycle (combinational); return to IDLE next edge; no resp forwarded.
- `a_pmem_resp` outside SERVE_X: ignored, not forwarded.
- D-cache read and write both high: write wins; `a_pmem_read` forced 0.
- `a_pmem_read` = (SERVE_I & `i_pmem_read`) | (SERVE_D & `d_pmem_read` & ~`d_pmem_write`); `a_pmem_write` = SERVE_D & `d_pmem_write`.
- `a_pmem_address` = SERVE_I ? `i_pmem_address` : `d_pmem_address`.
- `a_pmem_wdata` = `d_pmem_wdata` always.
- `i_pmem_rdata` = `d_pmem_rdata` = `a_pmem_rdata` always; resp qualifies.
- Wait counters increment when their request is high and their SERVE state is not current, IDLE included. They saturate at 2^PERF_W-1.

## Timing
- Reset values: state IDLE, `last_d` = 0 (D wins first tie), all counters 0, all resp/read/write outputs 0.
- Request seen high in IDLE at edge N: SERVE state and L2 read/write asserted from cycle N+1.
- Resp is combinational from `a_pmem_resp` (zero added latency).
- One mandatory IDLE bubble between consecutive grants.
- Minimum request-to-resp latency = 1 + L2 latency.
- Requesters must hold request, address and wdata stable until resp. They must drop the request the cycle after resp.
- `rst` mid-transaction: return to IDLE at the next edge and drop the L2 request. The in-flight L2 transaction is abandoned; the L2 is reset by the same `rst`.

## Structure
- `arb_state_t` enum (IDLE, SERVE_I, SERVE_D) and `perf_counter_width` go in `rv32i_types`.
- Counters use one sub-module, `sat_counter` (parameterized width, synchronous clear, enable), instantiated three times.
- No separate datapath module; muxing lives in this block.

## Test plan
- I only, `i_pmem_address`=0x0000_1000, L2 resp after 5 cycles → `a_pmem_read`=1 from cycle 1; `i_pmem_resp` one cycle; `grant_count`=1; `d_pmem_resp` stays 0.
- I and D read asserted together after reset → D granted first. After D resp and one IDLE cycle, I granted; `i_wait_cycles` = D service time + 1.
- Back-to-back simultaneous requests over 4 grants → order D, I, D, I; `grant_count`=4.
- D `d_pmem_read`=`d_pmem_write`=1, wdata=0xA5 repeated → `a_pmem_write`=1, `a_pmem_read`=0, `a_pmem_wdata` matches.
- `rst` pulsed in SERVE_I before resp → next cycle IDLE, `a_pmem_read`=0, counters 0. A late `a_pmem_resp` produces no `i_pmem_resp`.
- PERF_W=4, I starved by a 20-cycle D service → `i_wait_cycles` holds at 15.
